// File: rtl/cascade_idelay_cal_ctrl.sv
// cascade_idelay_cal_ctrl
// Per-lane IDELAY tap calibration controller for the cascade PHY input path.
// Lanes are calibrated one at a time. For each lane the controller loads
// taps 0..31 in turn. At each tap it checks a clock-rate toggling training
// pattern. It then finds the longest passing window and loads that
// window's centre tap. A lane with no adequate window gets DEFAULT_TAP and
// a sticky fail flag.
//
// Optional build feature: `define CASCADE_CAL_MANUAL_EN adds manual
// CE/INC/LD/VAL inputs. While the controller is idle these bypass the
// controller outputs. While it is busy they are ignored.
//
// Ports:
//   i_clk        delay-control / sampling clock
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle start pulse (ignored while o_busy)
//   i_lane       delayed lane data, CMD lanes in the LSBs, DAT lanes above
//   o_delay_ce   IDELAY CE   (0 unless manual bypass)
//   o_delay_inc  IDELAY INC  (0 unless manual bypass)
//   o_delay_ld   IDELAY LD pulse, at most one lane per cycle
//   o_delay_val  CNTVALUEIN, lane k at [k*5+4:k*5]
//   o_busy       calibration in progress
//   o_done       one-cycle pulse after the last lane's final load
//   o_lane_fail  sticky per-lane failure flags, cleared on start
module cascade_idelay_cal_ctrl #(
  parameter int LANES       = 3,
  parameter int SETTLE_CYC  = 8,
  parameter int CHECK_LEN   = 32,
  parameter int MIN_WIN     = 4,
  parameter int DEFAULT_TAP = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [LANES-1:0]   i_lane,
`ifdef CASCADE_CAL_MANUAL_EN
  input  logic [LANES-1:0]   i_man_ce,
  input  logic [LANES-1:0]   i_man_inc,
  input  logic [LANES-1:0]   i_man_ld,
  input  logic [LANES*5-1:0] i_man_val,
`endif
  output logic [LANES-1:0]   o_delay_ce,
  output logic [LANES-1:0]   o_delay_inc,
  output logic [LANES-1:0]   o_delay_ld,
  output logic [LANES*5-1:0] o_delay_val,
  output logic               o_busy,
  output logic               o_done,
  output logic [LANES-1:0]   o_lane_fail
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE   = LW'(LANES - 1);
  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]   CHECK_LAST  = 16'(CHECK_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_EVAL   = 3'd4,
    ST_FINAL  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t             state_r, state_s;
  logic [LW-1:0]      lane_r;
  logic [4:0]         tap_r;
  logic [15:0]        cnt_r;
  logic               prev_r, pass_r;
  logic [4:0]         cur_start_r, best_start_r;
  logic [5:0]         cur_len_r, best_len_r;
  logic [LANES-1:0]   ld_r, fail_r;
  logic [LANES*5-1:0] val_r;
  logic               busy_r, done_r;

  logic               sample_s;
  logic [4:0]         cur_start_s, best_start_s, centre_s;
  logic [5:0]         cur_len_s, best_len_s, centre_sum_s;
  logic               win_ok_s;
  int                 base_s, next_base_s;

  assign sample_s    = i_lane[lane_r];
  assign base_s      = int'(lane_r) * 5;
  assign next_base_s = (int'(lane_r) + 1) * 5;

  // Next-state decode for the calibration sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (i_start) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD:   state_s = ST_SETTLE;
      ST_SETTLE: if (cnt_r == SETTLE_LAST) state_s = ST_CHECK; else state_s = ST_SETTLE;
      ST_CHECK:  if (cnt_r == CHECK_LAST) state_s = ST_EVAL; else state_s = ST_CHECK;
      ST_EVAL:   if (tap_r == 5'd31) state_s = ST_FINAL; else state_s = ST_LOAD;
      ST_FINAL:  if (lane_r == LAST_LANE) state_s = ST_DONE; else state_s = ST_LOAD;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Window tracker update for the tap just checked, plus the centre of the
  // best window. The centre only matters at tap 31. At that tap the open
  // window is always closed, so the post-update best values are final.
  always_comb begin
    cur_start_s  = cur_start_r;
    cur_len_s    = cur_len_r;
    best_start_s = best_start_r;
    best_len_s   = best_len_r;
    if (pass_r) begin
      if (cur_len_r == 6'd0) cur_start_s = tap_r; else cur_start_s = cur_start_r;
      cur_len_s = cur_len_r + 6'd1;
    end else begin
      cur_len_s = cur_len_r;
    end
    if (!pass_r || (tap_r == 5'd31)) begin
      // Strictly greater: on a tie the earlier (lower-start) window stays best.
      if (cur_len_s > best_len_r) begin
        best_start_s = cur_start_s;
        best_len_s   = cur_len_s;
      end else begin
        best_len_s   = best_len_r;
      end
      cur_len_s = 6'd0;
    end else begin
      best_len_s = best_len_r;
    end
    win_ok_s     = (best_len_s >= 6'(MIN_WIN));
    centre_sum_s = {1'b0, best_start_s} + {1'b0, best_len_s[5:1]};
    if (!win_ok_s) begin
      centre_s = 5'(DEFAULT_TAP);
    end else if (centre_sum_s > 6'd31) begin
      centre_s = 5'd31;
    end else begin
      centre_s = centre_sum_s[4:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Datapath: tap/lane/counter sequencing, window trackers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_r       <= '0;
      tap_r        <= 5'd0;
      cnt_r        <= 16'd0;
      prev_r       <= 1'b0;
      pass_r       <= 1'b0;
      cur_start_r  <= 5'd0;
      cur_len_r    <= 6'd0;
      best_start_r <= 5'd0;
      best_len_r   <= 6'd0;
      ld_r         <= '0;
      fail_r       <= '0;
      val_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      ld_r   <= '0;
      done_r <= 1'b0;
`ifdef CASCADE_CAL_MANUAL_EN
      // Manual loads while idle keep the registered tap copy in step.
      if (!busy_r) begin
        for (int k = 0; k < LANES; k++) begin
          if (i_man_ld[k]) val_r[k*5 +: 5] <= i_man_val[k*5 +: 5];
        end
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            busy_r       <= 1'b1;
            lane_r       <= '0;
            tap_r        <= 5'd0;
            fail_r       <= '0;
            cur_start_r  <= 5'd0;
            cur_len_r    <= 6'd0;
            best_start_r <= 5'd0;
            best_len_r   <= 6'd0;
            ld_r         <= LANES'(1);
            val_r[4:0]   <= 5'd0;
          end
        end
        ST_LOAD: cnt_r <= 16'd0;
        ST_SETTLE: begin
          // The last settle-cycle sample is the reference for the first check sample.
          prev_r <= sample_s;
          pass_r <= 1'b1;
          if (cnt_r == SETTLE_LAST) cnt_r <= 16'd0;
          else                      cnt_r <= cnt_r + 16'd1;
        end
        ST_CHECK: begin
          if (sample_s == prev_r) pass_r <= 1'b0;
          prev_r <= sample_s;
          cnt_r  <= cnt_r + 16'd1;
        end
        ST_EVAL: begin
          cur_start_r  <= cur_start_s;
          cur_len_r    <= cur_len_s;
          best_start_r <= best_start_s;
          best_len_r   <= best_len_s;
          ld_r[lane_r] <= 1'b1;
          if (tap_r != 5'd31) begin
            tap_r                 <= tap_r + 5'd1;
            val_r[base_s +: 5]    <= tap_r + 5'd1;
          end else begin
            val_r[base_s +: 5]    <= centre_s;
            if (!win_ok_s) fail_r[lane_r] <= 1'b1;
          end
        end
        ST_FINAL: begin
          tap_r        <= 5'd0;
          cur_start_r  <= 5'd0;
          cur_len_r    <= 6'd0;
          best_start_r <= 5'd0;
          best_len_r   <= 6'd0;
          if (lane_r != LAST_LANE) begin
            lane_r                  <= lane_r + LW'(1);
            ld_r[lane_r + LW'(1)]   <= 1'b1;
            val_r[next_base_s +: 5] <= 5'd0;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ST_DONE: done_r <= 1'b0;
        default: done_r <= 1'b0;
      endcase
    end
  end

`ifdef CASCADE_CAL_MANUAL_EN
  assign o_delay_ce  = busy_r ? '0    : i_man_ce;
  assign o_delay_inc = busy_r ? '0    : i_man_inc;
  assign o_delay_ld  = busy_r ? ld_r  : i_man_ld;
  assign o_delay_val = busy_r ? val_r : i_man_val;
`else
  assign o_delay_ce  = '0;
  assign o_delay_inc = '0;
  assign o_delay_ld  = ld_r;
  assign o_delay_val = val_r;
`endif
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_lane_fail = fail_r;

endmodule

// File: tb/tb_cascade_idelay_cal_ctrl.sv
// Testbench for cascade_idelay_cal_ctrl. A lane model toggles each lane
// every cycle while its loaded tap is inside that lane's window. Expected
// final loads and o_done timing are queued when a run is started. A
// negedge monitor pops and compares them as the DUT produces them.
module tb_cascade_idelay_cal_ctrl;
  localparam int LANES = 3;
  localparam int S     = 4;
  localparam int C     = 16;
  localparam int RUN_CYC = LANES * (32 * (2 + S + C) + 1) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LANES-1:0]   lane_q = '0;
  logic [LANES-1:0]   ce, inc, ld, fail;
  logic [LANES*5-1:0] val;
  logic               busy, done;
  logic [LANES-1:0]   man_ce = '0, man_inc = '0, man_ld = '0;
  logic [LANES*5-1:0] man_val = '0;

  logic [LANES*5-1:0] tapm = '0;
  logic [31:0]        win [LANES];

  typedef struct { int lane; int val; int fail; } fin_t;
  fin_t fin_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   ld_cnt [LANES];

  cascade_idelay_cal_ctrl #(
    .LANES(LANES), .SETTLE_CYC(S), .CHECK_LEN(C), .MIN_WIN(4), .DEFAULT_TAP(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_lane(lane_q),
`ifdef CASCADE_CAL_MANUAL_EN
    .i_man_ce(man_ce), .i_man_inc(man_inc), .i_man_ld(man_ld), .i_man_val(man_val),
`endif
    .o_delay_ce(ce), .o_delay_inc(inc), .o_delay_ld(ld), .o_delay_val(val),
    .o_busy(busy), .o_done(done), .o_lane_fail(fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // IDELAY + training-pattern model: LD loads the tap, and an in-window tap toggles the lane.
  always @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (ld[k]) tapm[k*5 +: 5] <= val[k*5 +: 5];
      if (win[k][tapm[k*5 +: 5]]) lane_q[k] <= ~lane_q[k];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int t = 0; t < 32; t++) if (t >= lo && t <= hi) m[t] = 1'b1;
    return m;
  endfunction

  // Monitor: LD exclusivity, sweep values, final loads and o_done timing.
  always @(negedge clk) begin
    if (!rst_n || !busy) begin
      for (int k = 0; k < LANES; k++) ld_cnt[k] = 0;
    end
    if (rst_n) begin
      if (busy && ld != '0) chk("ld_onehot", 32'($onehot(ld)), 32'd1);
      for (int k = 0; k < LANES; k++) begin
        if (busy && ld[k]) begin
          ld_cnt[k]++;
          if (ld_cnt[k] <= 32) begin
            chk("sweep_val", 32'(val[k*5 +: 5]), 32'(ld_cnt[k] - 1));
          end else if (ld_cnt[k] == 33) begin
            if (fin_q.size() == 0) begin
              chk("unexpected_final", 32'(k), 32'hFFFF_FFFF);
            end else begin
              fin_t e;
              e = fin_q.pop_front();
              chk("final_lane", 32'(k), 32'(e.lane));
              chk("final_val", 32'(val[k*5 +: 5]), 32'(e.val));
              chk("final_fail", 32'(fail[k]), 32'(e.fail));
            end
          end else begin
            chk("extra_ld", 32'(ld_cnt[k]), 32'd33);
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        else                    chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic start_run(input int v0, input int f0, input int v1, input int f1,
                           input int v2, input int f2);
    fin_t e;
    @(negedge clk);
    start = 1'b1;
    e.lane = 0; e.val = v0; e.fail = f0; fin_q.push_back(e);
    e.lane = 1; e.val = v1; e.fail = f1; fin_q.push_back(e);
    e.lane = 2; e.val = v2; e.fail = f2; fin_q.push_back(e);
    done_q.push_back(cyc + RUN_CYC);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("fail_cleared", 32'(fail), 32'd0);
  endtask

  task automatic wait_done();
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < RUN_CYC + 50) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'(done_cnt), 32'(d0 + 1));
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_ld"}, 32'(ld), 32'd0);
    chk({name, "_val"}, 32'(val), 32'd0);
    chk({name, "_fail"}, 32'(fail), 32'd0);
    chk({name, "_ce_inc"}, 32'({ce, inc}), 32'd0);
  endtask

  initial begin
    int l1_val;
    l1_val = 0;
    win[0] = '0; win[1] = '0; win[2] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

`ifdef CASCADE_CAL_MANUAL_EN
    // Idle manual bypass on lane 1.
    man_ld = 3'b010;
    man_val = 15'd7 << 5;
    #1;
    chk("man_idle_ld", 32'(ld), 32'd2);
    chk("man_idle_val", 32'(val[9:5]), 32'd7);
    @(negedge clk);
    man_ld = '0;
    man_val = '0;
    l1_val = 7;
`endif

    // Run 1: single windows, two-window lane and the full-range window.
    win[0] = mk(10, 20);
    win[1] = mk(2, 5) | mk(20, 27);
    win[2] = 32'hFFFF_FFFF;
    start_run(15, 0, 24, 0, 16, 0);
    repeat (100) @(negedge clk);
    start = 1'b1;
`ifdef CASCADE_CAL_MANUAL_EN
    man_ld = 3'b010; man_val = 15'd9 << 5; man_ce = '1; man_inc = '1;
`endif
    #1;
    chk("busy_ignores_ld1", 32'(ld[1]), 32'd0);
    chk("busy_val1_held", 32'(val[9:5]), 32'(l1_val));
    chk("busy_ce_inc", 32'({ce, inc}), 32'd0);
    @(negedge clk);
    start = 1'b0;
    man_ld = '0; man_val = '0; man_ce = '0; man_inc = '0;
    wait_done();

    // Run 2: window touching tap 31, tied windows, too-narrow window.
    win[0] = mk(25, 31);
    win[1] = mk(3, 6) | mk(20, 23);
    win[2] = mk(8, 10);
    start_run(28, 0, 5, 0, 16, 1);
    wait_done();
    chk("fail_sticky", 32'(fail), 32'd4);

    // Run 3: abort with reset during lane 1 CHECK.
    win[0] = mk(10, 20);
    win[1] = mk(2, 5) | mk(20, 27);
    win[2] = 32'hFFFF_FFFF;
    start_run(15, 0, 24, 0, 16, 0);
    repeat (711) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    fin_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Run 4: restart after the abort completes normally.
    start_run(15, 0, 24, 0, 16, 0);
    wait_done();

    chk("done_count", 32'(done_cnt), 32'd3);
    chk("queues_drained", 32'(fin_q.size() + done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
